dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the load/store port of the pipelined RISC-V core that runs the merge-sort program.
- The pipeline's MEM stage is the initiator. This block is the other end: it accepts one request at a time, performs the word read or write, and returns a response after a programmable number of wait states.
- It lets the hazard/stall logic be exercised against a slow memory, and it gives benches a clean end-of-program signal.

Parameters:
- ADDR_W, 32, width of the byte address.
- DEPTH_WORDS, 1024, number of 32-bit words stored.
- LATENCY, 1, extra wait cycles between accept and response. Legal range 0..15.
- MAILBOX_ADDR, 32'h0000_0FFC, byte address of the completion mailbox. Used only when the optional feature is compiled in.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables. Bit i enables byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  32  read data. 0 for writes and for errors.
- resp_err  out  1  misaligned or out-of-range access.
- done  out  1  present only with the optional feature.
- done_code  out  32  present only with the optional feature.

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait_cnt=0, done=0, done_code=0. Memory array contents are not reset.
- State machine: IDLE, WAIT, RESP. At most one request is outstanding.
- IDLE: req_ready=1.
  - If req_valid is high at a rising edge, the request is accepted.
  - The access is performed at that same edge, and resp_rdata/resp_err are captured into registers.
  - Next state is WAIT with wait_cnt=LATENCY if LATENCY>0; otherwise next state is RESP.
- WAIT: req_ready=0. wait_cnt decrements by 1 each cycle. When wait_cnt==1, go to RESP on the next edge.
- RESP: req_ready=0, resp_valid=1.
  - resp_rdata and resp_err stay stable until resp_ready is sampled high.
  - At that edge, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - A request cannot be accepted in the same edge as the response handshake; the earliest new accept is one cycle later.
- Latency: an accept at edge N gives resp_valid high after edge N+1+LATENCY.
- Error check:
  - word index = req_addr[ADDR_W-1:2].
  - err = (req_addr[1:0]!=0) or (index >= DEPTH_WORDS).
  - On err: no memory write, resp_rdata=0, resp_err=1.
- Write (req_we=1, no err):
  - For each i with req_wstrb[i]=1, mem[index] byte i takes req_wdata byte i. Other bytes are unchanged.
  - req_wstrb=0 is a legal no-op write.
  - resp_rdata=0.
- Read (req_we=0, no err): resp_rdata = mem[index]. req_wstrb and req_wdata are ignored.
- Ordering: the write is committed at accept, so a later read always sees it.
- Reset mid-transaction: any in-flight response is discarded and the FSM returns to IDLE. A write already committed at accept stays in memory.
- Inputs sampled while req_ready=0 are ignored. The initiator must hold the request until it is accepted.

Optional Feature:
- Macro: DMEM_DONE_MAILBOX_EN.
- With the macro defined:
  - An error-free write to MAILBOX_ADDR sets done=1 (sticky until reset) and loads done_code with the merged word value.
  - The write also updates memory normally.
  - A later mailbox write updates done_code; done stays 1.
- Without the macro: the done and done_code ports do not exist, and MAILBOX_ADDR is an ordinary address.

Test Plan:
- LATENCY=0. Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10 → read response one cycle after accept with rdata 0xDEADBEEF, err 0.
- Partial write: after the line above, write 0x10 with wdata 0x00AA0000, wstrb 0x4; read 0x10 → 0xDEAABEEF.
- LATENCY=3, resp_ready held low for 5 cycles → resp_valid rises exactly 4 cycles after accept. rdata stays constant while held. req_ready stays 0 until one cycle after the resp_ready handshake.
- Errors: read 0x13 → err=1, rdata=0. Write 0x1000 with DEPTH_WORDS=1024 → err=1; a following read of 0x0 returns its old value unchanged.
- Reset asserted in WAIT after a write to 0x20 with 0x12345678 → resp_valid drops immediately and state returns to IDLE. After reset release, read 0x20 → 0x12345678.
- DMEM_DONE_MAILBOX_EN: write 0xFFC with 0x0000_0001 → done=1, done_code=1 after the accept edge. Then write 0xFFC with 0x2 → done_code=2, done still 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// Optional completion mailbox: define DMEM_DONE_MAILBOX_EN.
module dmem_responder #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DEPTH_WORDS  = 1024,
    parameter int unsigned       LATENCY      = 1,
    parameter logic [ADDR_W-1:0] MAILBOX_ADDR = 32'h0000_0FFC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
`ifdef DMEM_DONE_MAILBOX_EN
    ,
    output logic              done,
    output logic [31:0]       done_code
`endif
);

    localparam int unsigned IDX_W =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              addr_err;
    logic              accept;
    logic              wr_en;
    logic              mb_hit;
    logic [31:0]       old_word;
    logic [31:0]       merged;

    assign word_idx = {2'b00, req_addr[ADDR_W-1:2]};
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      (word_idx >= ADDR_W'(DEPTH_WORDS));
    assign accept   = (state_q == S_IDLE) && req_valid && !reset;
    assign wr_en    = accept && req_we && !addr_err;
    assign mb_hit   = wr_en && (req_addr == MAILBOX_ADDR);
    assign old_word = mem[mem_idx];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Byte-lane merge of write data over the currently stored word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (req_wstrb[i]) begin
                merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // Storage: writes commit on the accept edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[mem_idx] <= merged;
        end
    end

    // Next-state logic; resp_valid rises one edge after entering RESP.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_d = (req_we || addr_err) ? 32'h0 : old_word;
                    err_d   = addr_err;
                    if (LATENCY > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 4'(LATENCY);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    rdata_d      = 32'h0;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 4'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

`ifdef DMEM_DONE_MAILBOX_EN
    logic        done_q;
    logic [31:0] done_code_q;

    assign done      = done_q;
    assign done_code = done_code_q;

    // Sticky completion flag, code tracks the latest mailbox write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            done_code_q <= 32'h0;
        end else if (mb_hit) begin
            done_q      <= 1'b1;
            done_code_q <= merged;
        end
    end
`else
    logic unused_mb;
    assign unused_mb = mb_hit;
`endif

endmodule
